match_len_accumulator: RTL
==========================

// Module: match_len_accumulator
// PURPOSE
//  Consumer of per-window match-length segments {match_len, can_ext}; each comes from one
//  MASK_WIDTH-byte compare window. Sums segments of one match until can_ext=0, then emits
//  the total match length with a captured tag. Sits after the compare/encode stage, before
//  sequence packing. Valid/ready handshake on both sides.
// PARAMETERS
//  MASK_WIDTH       14   bytes per compare window = max segment length
//  MATCH_LEN_WIDTH  5    segment length width (holds 0..MASK_WIDTH)
//  TOTAL_LEN_WIDTH  16   accumulated length width
//  TAG_WIDTH        16   opaque per-match tag (e.g. position/offset), passed through
//  MAX_MATCH_LEN    1024 clamp value, used only with MATCH_LEN_ACC_SATURATE_EN
// PORTS
//  clk            in   1                clock
//  rst            in   1                synchronous, active-high reset
//  in_valid       in   1                segment valid
//  in_ready       out  1                segment accepted when in_valid&in_ready
//  in_match_len   in   MATCH_LEN_WIDTH  segment length, 0..MASK_WIDTH
//  in_can_ext     in   1                1: match continues in next segment; 0: last segment
//  in_tag         in   TAG_WIDTH        sampled on first segment of a match only
//  out_valid      out  1                total length valid
//  out_ready      in   1                downstream accept
//  out_match_len  out  TOTAL_LEN_WIDTH  summed length of all segments of the match
//  out_tag        out  TAG_WIDTH        tag from first segment
//  out_saturated  out  1                1 if total was clamped (0 when macro absent)
// BEHAVIOUR
//  - One clock (clk); reset synchronous, active-high (rst). On reset: state=IDLE,
//    acc=0, out_valid=0, out_match_len=0, out_tag=0, out_saturated=0; in-flight match
//    dropped with no output. rst wins over all same-cycle events.
//  - States: IDLE (no match open), ACC (match open), DRAIN (macro only), OUT (result held).
//  - IDLE: in_ready=1. On accept: tag<=in_tag; if can_ext=0 -> out_match_len=in_match_len,
//    OUT; else acc<=in_match_len, ACC.
//  - ACC: in_ready=1. On accept: sum=acc+in_match_len (TOTAL_LEN_WIDTH, zero-extended);
//    can_ext=0 -> out_match_len=sum, OUT; else acc<=sum, stay.
//  - OUT: out_valid=1, outputs stable until out_ready. in_ready=out_ready (accept a new
//    first segment in the out_ready cycle, processed as from IDLE); out_ready with no
//    input -> IDLE.
//  - Latency: out_valid is asserted the cycle after the last segment is accepted.
//    Throughput: one segment/cycle; one match of 1 segment/cycle sustained.
//  - Segment with match_len=0 and can_ext=0 is legal: emits total = acc (0 from IDLE).
//  - in_match_len>MASK_WIDTH, or can_ext=1 with match_len<MASK_WIDTH: illegal input,
//    summed as given (assertion in bench only).
//  - No saturation without the macro: sum wraps modulo 2^TOTAL_LEN_WIDTH.
// CONFIGURATION
//  MATCH_LEN_ACC_SATURATE_EN defined: if sum>=MAX_MATCH_LEN, out_match_len=MAX_MATCH_LEN,
//    out_saturated=1; if that segment had can_ext=1 -> DRAIN (in_ready=1, discard segments;
//    first with can_ext=0 -> OUT), else -> OUT.
//  Undefined: no DRAIN state, no compare logic, out_saturated tied 0, wrap as above.
// STRUCTURE
//  Shared package/header: state encoding localparams (IDLE/ACC/DRAIN/OUT), ZERO_EXTEND
//  helper in util.vh. Single module, no sub-modules; output register is the result stage.
// TESTING (MASK_WIDTH=14)
//  1 single seg {5,0} tag=0x12 -> next cycle out_valid, len=5, tag=0x12.
//  2 {14,1},{14,1},{3,0}, tag=0xAB on 1st, 0xFF later -> len=31, tag=0xAB.
//  3 out_ready=0 for 4 cycles in OUT -> outputs stable, in_ready=0; then out_ready=1 with
//    new {7,0} same cycle -> 31 retired, next output len=7, no bubble.
//  4 rst=1 mid-match after {14,1},{14,1} -> no output; then {2,0} -> len=2.
//  5 SATURATE_EN, MAX=20: {14,1},{14,1},{14,1},{1,0} -> one output len=20, saturated=1;
//    all 4 segments accepted. Macro off: same stream -> len=43, saturated=0.
//  6 random back-to-back matches, random in_valid/out_ready -> scoreboard sums match.

Source files
------------

// File: rtl/match_len_accumulator_pkg.sv
// Shared types for the match-length accumulator: FSM state encoding and default widths.
package match_len_accumulator_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAcc   = 2'd1,
        StDrain = 2'd2,
        StOut   = 2'd3
    } state_e;

    localparam int unsigned DefMaskWidth     = 14;
    localparam int unsigned DefMatchLenWidth = 5;
    localparam int unsigned DefTotalLenWidth = 16;
    localparam int unsigned DefTagWidth      = 16;
    localparam int unsigned DefMaxMatchLen   = 1024;

endpackage

// File: rtl/match_len_accumulator.sv
// Sums per-window match segments until can_ext=0, then presents total length and first tag.
// Optional clamping to MAX_MATCH_LEN is enabled by defining MATCH_LEN_ACC_SATURATE_EN.
module match_len_accumulator
    import match_len_accumulator_pkg::*;
#(
    parameter int unsigned MASK_WIDTH      = DefMaskWidth,
    parameter int unsigned MATCH_LEN_WIDTH = DefMatchLenWidth,
    parameter int unsigned TOTAL_LEN_WIDTH = DefTotalLenWidth,
    parameter int unsigned TAG_WIDTH       = DefTagWidth,
    parameter int unsigned MAX_MATCH_LEN   = DefMaxMatchLen
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [MATCH_LEN_WIDTH-1:0] in_match_len,
    input  logic                       in_can_ext,
    input  logic [TAG_WIDTH-1:0]       in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TOTAL_LEN_WIDTH-1:0] out_match_len,
    output logic [TAG_WIDTH-1:0]       out_tag,
    output logic                       out_saturated
);

    if (($clog2(MASK_WIDTH + 1) > MATCH_LEN_WIDTH) || (MATCH_LEN_WIDTH > TOTAL_LEN_WIDTH) ||
        (MAX_MATCH_LEN == 0)) begin : g_bad_params
        $error("match_len_accumulator: inconsistent width parameters");
    end

    state_e                     state_q, state_d;
    logic [TOTAL_LEN_WIDTH-1:0] acc_q, acc_d;
    logic [TAG_WIDTH-1:0]       tag_q, tag_d;
    logic [TOTAL_LEN_WIDTH-1:0] out_len_q, out_len_d;
    logic [TAG_WIDTH-1:0]       out_tag_q, out_tag_d;

    logic                       accept;
    logic                       first_seg;
    logic [TOTAL_LEN_WIDTH-1:0] sum;
    logic [TAG_WIDTH-1:0]       match_tag;

    assign in_ready  = (state_q != StOut) || out_ready;
    assign accept    = in_valid && in_ready;
    // An accepted segment in OUT is the first of a new match, exactly as from IDLE.
    assign first_seg = (state_q == StIdle) || (state_q == StOut);
    assign sum       = (first_seg ? '0 : acc_q) + TOTAL_LEN_WIDTH'(in_match_len);
    assign match_tag = first_seg ? in_tag : tag_q;

`ifdef MATCH_LEN_ACC_SATURATE_EN
    localparam logic [TOTAL_LEN_WIDTH-1:0] MaxLen = TOTAL_LEN_WIDTH'(MAX_MATCH_LEN);
    logic out_sat_q, out_sat_d;
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        tag_d     = tag_q;
        out_len_d = out_len_q;
        out_tag_d = out_tag_q;
`ifdef MATCH_LEN_ACC_SATURATE_EN
        out_sat_d = out_sat_q;
`endif

        if (state_q == StOut && out_ready) begin
            state_d = StIdle;
        end

        if (accept && state_q != StDrain) begin
            tag_d = match_tag;
            if (!in_can_ext) begin
                out_len_d = sum;
                out_tag_d = match_tag;
                state_d   = StOut;
            end else begin
                acc_d   = sum;
                state_d = StAcc;
            end
`ifdef MATCH_LEN_ACC_SATURATE_EN
            out_sat_d = 1'b0;
            if (sum >= MaxLen) begin
                out_len_d = MaxLen;
                out_tag_d = match_tag;
                out_sat_d = 1'b1;
                state_d   = in_can_ext ? StDrain : StOut;
            end
`endif
        end

`ifdef MATCH_LEN_ACC_SATURATE_EN
        // Result already latched on entry; remaining segments of this match are discarded.
        if (state_q == StDrain && accept && !in_can_ext) begin
            state_d = StOut;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            tag_q     <= '0;
            out_len_q <= '0;
            out_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            tag_q     <= tag_d;
            out_len_q <= out_len_d;
            out_tag_q <= out_tag_d;
        end
    end

`ifdef MATCH_LEN_ACC_SATURATE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            out_sat_q <= 1'b0;
        end else begin
            out_sat_q <= out_sat_d;
        end
    end
    assign out_saturated = out_sat_q;
`else
    assign out_saturated = 1'b0;
`endif

    assign out_valid     = (state_q == StOut);
    assign out_match_len = out_len_q;
    assign out_tag       = out_tag_q;

endmodule
